// File: rtl/vreg_file_dma.sv
// Vector register file: two registered read ports, masked full-vector write,
// and a word-by-word streaming load from the DMA engine.
module vreg_file_dma #(
  parameter  int wordSize = 32,
  parameter  int words    = 16,
  parameter  int NoOfElem = 16,
  localparam int AW       = $clog2(NoOfElem),
  localparam int VW       = words * wordSize,
  localparam int IW       = (words > 1) ? $clog2(words) : 1
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [words-1:0]    wr_mask,
  input  logic [VW-1:0]       wr_data,
  output logic                wr_err,
  input  logic                rd_en_a,
  input  logic [AW-1:0]       rd_addr_a,
  output logic [VW-1:0]       rd_data_a,
  output logic                rd_valid_a,
  input  logic                rd_en_b,
  input  logic [AW-1:0]       rd_addr_b,
  output logic [VW-1:0]       rd_data_b,
  output logic                rd_valid_b,
  input  logic                ld_start,
  input  logic [AW-1:0]       ld_addr,
  output logic                ld_busy,
  output logic                ld_done,
  input  logic                s_valid,
  input  logic [wordSize-1:0] s_data,
  output logic                s_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [VW-1:0] r_mem [NoOfElem];
  logic [1:0]    r_state;
  logic [AW-1:0] r_tgt;
  logic [IW-1:0] r_idx;
  logic          r_wr_err;
  logic          r_rd_valid_a;
  logic          r_rd_valid_b;
  logic [VW-1:0] r_rd_data_a;
  logic [VW-1:0] r_rd_data_b;

  logic w_busy;
  logic w_beat;
  logic w_last;
  logic w_wr_ok;
  logic w_wr_bad;
  logic w_rd_ok_a;
  logic w_rd_ok_b;
  logic w_ld_ok;

  always_comb begin
    w_busy    = (r_state != IDLE);
    w_beat    = s_valid && (r_state == LOAD);
    w_last    = (r_idx == IW'(words - 1));
    w_ld_ok   = ld_start && (32'(ld_addr) < NoOfElem);
    // A register being streamed is locked against both writes and reads
    w_wr_ok   = wr_en && (32'(wr_addr) < NoOfElem)
                && !(w_busy && (wr_addr == r_tgt));
    w_wr_bad  = wr_en && !w_wr_ok;
    w_rd_ok_a = rd_en_a && (32'(rd_addr_a) < NoOfElem)
                && !(w_busy && (rd_addr_a == r_tgt));
    w_rd_ok_b = rd_en_b && (32'(rd_addr_b) < NoOfElem)
                && !(w_busy && (rd_addr_b == r_tgt));
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state <= IDLE;
      r_tgt   <= '0;
      r_idx   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_ld_ok) begin
            r_tgt   <= ld_addr;
            r_idx   <= '0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (s_valid) begin
            r_idx <= r_idx + 1'b1;
            if (w_last) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int r = 0; r < NoOfElem; r++) r_mem[r] <= '0;
    end else begin
      // Lock guarantees the stream and write port never hit the same register
      if (w_beat)
        r_mem[r_tgt][32'(r_idx)*wordSize +: wordSize] <= s_data;
      if (w_wr_ok) begin
        for (int i = 0; i < words; i++)
          if (wr_mask[i])
            r_mem[wr_addr][i*wordSize +: wordSize]
              <= wr_data[i*wordSize +: wordSize];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_wr_err     <= 1'b0;
      r_rd_valid_a <= 1'b0;
      r_rd_valid_b <= 1'b0;
      r_rd_data_a  <= '0;
      r_rd_data_b  <= '0;
    end else begin
      r_wr_err     <= w_wr_bad;
      r_rd_valid_a <= w_rd_ok_a;
      r_rd_valid_b <= w_rd_ok_b;
      if (w_rd_ok_a) r_rd_data_a <= r_mem[rd_addr_a];
      if (w_rd_ok_b) r_rd_data_b <= r_mem[rd_addr_b];
    end
  end

  assign wr_err     = r_wr_err;
  assign rd_valid_a = r_rd_valid_a;
  assign rd_valid_b = r_rd_valid_b;
  assign rd_data_a  = r_rd_data_a;
  assign rd_data_b  = r_rd_data_b;
  assign ld_busy    = w_busy;
  assign ld_done    = (r_state == DONE);
  assign s_ready    = (r_state == LOAD);

endmodule

// File: tb/tb_vreg_file_dma.sv
// Bench for vreg_file_dma: reference model of register contents plus
// per-port queues of expected read data.
module tb_vreg_file_dma;

  localparam int WS = 32;
  localparam int WD = 16;
  localparam int NE = 16;
  localparam int AW = 4;
  localparam int VW = WS * WD;

  logic          clk = 1'b0;
  logic          RESET;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WD-1:0] wr_mask;
  logic [VW-1:0] wr_data;
  logic          wr_err;
  logic          rd_en_a, rd_en_b;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [VW-1:0] rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b;
  logic          ld_start;
  logic [AW-1:0] ld_addr;
  logic          ld_busy, ld_done;
  logic          s_valid;
  logic [WS-1:0] s_data;
  logic          s_ready;

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] model [NE];
  logic [VW-1:0] qa [$];
  logic [VW-1:0] qb [$];

  always #5 clk = ~clk;

  vreg_file_dma #(.wordSize(WS), .words(WD), .NoOfElem(NE)) dut (
    .clk(clk), .RESET(RESET),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask),
    .wr_data(wr_data), .wr_err(wr_err),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .ld_start(ld_start), .ld_addr(ld_addr),
    .ld_busy(ld_busy), .ld_done(ld_done),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = '0; wr_mask = '0; wr_data = '0;
    rd_en_a = 0; rd_addr_a = '0; rd_en_b = 0; rd_addr_b = '0;
    ld_start = 0; ld_addr = '0; s_valid = 0; s_data = '0;
  endtask

  // Drive one read on each port, queue the model's view, and advance a cycle
  task automatic read_both(input logic [AW-1:0] aa, input logic [AW-1:0] ab);
    rd_en_a = 1; rd_addr_a = aa; qa.push_back(model[aa]);
    rd_en_b = 1; rd_addr_b = ab; qb.push_back(model[ab]);
    tick();
    rd_en_a = 0; rd_en_b = 0;
  endtask

  task automatic test_reset();
    logic [VW-1:0] ea, eb;
    idle_inputs();
    RESET = 1;
    tick(); tick();
    RESET = 0;
    for (int r = 0; r < NE; r++) model[r] = '0;
    checks++;
    if ({ld_busy, s_ready, ld_done, wr_err, rd_valid_a, rd_valid_b} !== 6'b0
        || rd_data_a !== '0 || rd_data_b !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b rdy=%b done=%b err=%b va=%b vb=%b",
               ld_busy, s_ready, ld_done, wr_err, rd_valid_a, rd_valid_b);
    end
    read_both(4'd0, 4'd15);
    ea = qa.pop_front(); eb = qb.pop_front();
    checks++;
    if (rd_valid_a !== 1'b1 || rd_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_rd_valid: va=%b vb=%b required 1 1",
               rd_valid_a, rd_valid_b);
    end
    checks++;
    if (rd_data_a !== ea || rd_data_b !== eb) begin
      errors++;
      $display("FAIL reset_rd_data: a=%h b=%h required 0",
               rd_data_a[63:0], rd_data_b[63:0]);
    end
  endtask

  task automatic test_mask_write();
    logic [VW-1:0] ea, eb;
    wr_en = 1; wr_addr = 4'd3; wr_mask = 16'h0005;
    for (int i = 0; i < WD; i++) wr_data[i*WS +: WS] = 32'hA000_0000 + i;
    model[3][0*WS +: WS] = 32'hA000_0000;
    model[3][2*WS +: WS] = 32'hA000_0002;
    tick();
    idle_inputs();
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL mask_wr_err: got %b required 0", wr_err);
    end
    read_both(4'd3, 4'd3);
    ea = qa.pop_front(); eb = qb.pop_front();
    checks++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== ea) begin
      errors++;
      $display("FAIL mask_read_a: v=%b got %h required %h",
               rd_valid_a, rd_data_a[127:0], ea[127:0]);
    end
    checks++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== eb) begin
      errors++;
      $display("FAIL mask_read_b: v=%b got %h required %h",
               rd_valid_b, rd_data_b[127:0], eb[127:0]);
    end
  endtask

  task automatic test_load_conflicts();
    int beats = 0;
    int cyc = 0;
    int dones = 0;
    int rdy_bad = 0;
    logic acc;
    logic [VW-1:0] ea, eb;
    ld_start = 1; ld_addr = 4'd5;
    tick();
    idle_inputs();
    checks++;
    if (ld_busy !== 1'b1 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_enter: busy=%b rdy=%b required 1 1", ld_busy, s_ready);
    end
    while (beats < WD && cyc < 200) begin
      idle_inputs();
      s_valid = (cyc % 3 != 2);
      s_data = 32'(100 + beats);
      if (cyc == 1) begin
        rd_en_a = 1; rd_addr_a = 4'd5;
        wr_en = 1; wr_addr = 4'd5; wr_mask = '1; wr_data = '1;
      end
      if (cyc == 4) begin
        wr_en = 1; wr_addr = 4'd6; wr_mask = '1;
        for (int i = 0; i < WD; i++) wr_data[i*WS +: WS] = 32'h6600_0000 + i;
        model[6] = wr_data;
      end
      if (s_ready !== 1'b1) rdy_bad++;
      acc = s_valid && s_ready;
      if (acc) model[5][beats*WS +: WS] = 32'(100 + beats);
      tick();
      if (acc) beats++;
      if (ld_done === 1'b1 && beats < WD) dones++;
      if (cyc == 1) begin
        checks++;
        if (rd_valid_a !== 1'b0 || wr_err !== 1'b1) begin
          errors++;
          $display("FAIL load_lock: va=%b err=%b required 0 1",
                   rd_valid_a, wr_err);
        end
      end
      if (cyc == 4) begin
        checks++;
        if (wr_err !== 1'b0) begin
          errors++;
          $display("FAIL load_other_wr_err: got %b required 0", wr_err);
        end
      end
      cyc++;
    end
    idle_inputs();
    checks++;
    if (beats != WD || rdy_bad != 0 || dones != 0) begin
      errors++;
      $display("FAIL load_stream: beats=%0d rdy_bad=%0d early_done=%0d",
               beats, rdy_bad, dones);
    end
    checks++;
    if (ld_done !== 1'b1 || ld_busy !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_done_state: done=%b busy=%b rdy=%b required 1 1 0",
               ld_done, ld_busy, s_ready);
    end
    tick();
    checks++;
    if (ld_done !== 1'b0 || ld_busy !== 1'b0) begin
      errors++;
      $display("FAIL load_back_idle: done=%b busy=%b required 0 0",
               ld_done, ld_busy);
    end
    read_both(4'd5, 4'd6);
    ea = qa.pop_front(); eb = qb.pop_front();
    checks++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== ea) begin
      errors++;
      $display("FAIL load_read_reg5: got %h required %h",
               rd_data_a[127:0], ea[127:0]);
    end
    checks++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== eb) begin
      errors++;
      $display("FAIL load_read_reg6: got %h required %h",
               rd_data_b[127:0], eb[127:0]);
    end
  endtask

  task automatic test_read_before_write();
    logic [VW-1:0] eb;
    wr_en = 1; wr_addr = 4'd2; wr_mask = '1; wr_data = '1;
    rd_en_b = 1; rd_addr_b = 4'd2; qb.push_back(model[2]);
    model[2] = '1;
    tick();
    idle_inputs();
    eb = qb.pop_front();
    checks++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== eb) begin
      errors++;
      $display("FAIL rbw_old: got %h required %h", rd_data_b[63:0], eb[63:0]);
    end
    read_both(4'd0, 4'd2);
    void'(qa.pop_front());
    eb = qb.pop_front();
    checks++;
    if (rd_data_b !== eb) begin
      errors++;
      $display("FAIL rbw_new: got %h required %h", rd_data_b[63:0], eb[63:0]);
    end
  endtask

  task automatic test_reset_mid_load();
    int beats = 0;
    int cyc = 0;
    int dones = 0;
    logic acc;
    logic [VW-1:0] ea, eb;
    ld_start = 1; ld_addr = 4'd9;
    tick();
    idle_inputs();
    for (int i = 0; i < 7; i++) begin
      s_valid = 1; s_data = 32'(500 + i);
      tick();
    end
    idle_inputs();
    RESET = 1;
    tick();
    RESET = 0;
    for (int r = 0; r < NE; r++) model[r] = '0;
    checks++;
    if (ld_busy !== 1'b0 || ld_done !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b rdy=%b required 0 0 0",
               ld_busy, ld_done, s_ready);
    end
    read_both(4'd9, 4'd5);
    ea = qa.pop_front(); eb = qb.pop_front();
    checks++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== ea || rd_data_b !== eb) begin
      errors++;
      $display("FAIL abort_cleared: r9=%h r5=%h required 0",
               rd_data_a[63:0], rd_data_b[63:0]);
    end
    ld_start = 1; ld_addr = 4'd9;
    tick();
    idle_inputs();
    while (dones == 0 && cyc < 100) begin
      s_valid = (beats < WD) && (cyc % 2 == 0);
      s_data = 32'hBEEF_0000 + 32'(beats);
      acc = s_valid && s_ready;
      if (acc) model[9][beats*WS +: WS] = s_data;
      tick();
      if (acc) beats++;
      if (ld_done === 1'b1) dones++;
      cyc++;
    end
    idle_inputs();
    tick();
    checks++;
    if (dones != 1 || beats != WD || ld_busy !== 1'b0) begin
      errors++;
      $display("FAIL reload_done: dones=%0d beats=%0d busy=%b required 1 16 0",
               dones, beats, ld_busy);
    end
    read_both(4'd9, 4'd9);
    ea = qa.pop_front(); eb = qb.pop_front();
    checks++;
    if (rd_data_a !== ea || rd_data_b !== eb) begin
      errors++;
      $display("FAIL reload_data: a=%h b=%h required %h",
               rd_data_a[127:0], rd_data_b[127:0], ea[127:0]);
    end
  endtask

  initial begin
    RESET = 1;
    idle_inputs();
    test_reset();
    test_mask_write();
    test_load_conflicts();
    test_read_before_write();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
